// File: rtl/regs_pkg.sv
// Shared definitions for the RV32I integer register file.
// Widths, zero constants and the debug handshake state type.
package regs_pkg;

    // Architectural register file geometry
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // Hardwired x0 value and its address
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;
    localparam logic [ADDR_W-1:0] ZERO_REG  = '0;

    // Debug port handshake states
    typedef enum logic [1:0] {
        DBG_IDLE     = 2'd0,
        DBG_ACK      = 2'd1,
        DBG_WAIT_LOW = 2'd2
    } dbg_state_e;

    // A write request into the register array
    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // True when a write to this address would actually change state
    function automatic logic is_live_wr(input wr_req_t w);
        return w.en && (w.addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/regs.sv
// 32x32 integer register file: two combinational read ports with
// same-cycle write bypass, one writeback port, and a req/ack debug port.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   reg1_raddr_i / reg1_rdata_o read port 1 (rs1), combinational
//   reg2_raddr_i / reg2_rdata_o read port 2 (rs2), combinational
//   reg_wen_i/waddr_i/wdata_i   writeback write port
//   dbg_req_i/we_i/addr_i/wdata_i debug request (held until ack)
//   dbg_ack_o, dbg_rdata_o      registered debug completion + read data
module regs
    import regs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] reg1_raddr_i,
    input  logic [ADDR_W-1:0] reg2_raddr_i,
    output logic [DATA_W-1:0] reg1_rdata_o,
    output logic [DATA_W-1:0] reg2_rdata_o,

    input  logic              reg_wen_i,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    input  logic [DATA_W-1:0] reg_wdata_i,

    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    dbg_state_e        state_q;
    logic              dbg_ack_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    wr_req_t           pipe_wr;
    wr_req_t           dbg_wr;
    wr_req_t           wr;
    logic              wr_live;
    logic              dbg_idle_req;
    logic              dbg_rd_acc;
    logic              dbg_wr_acc;
    logic [DATA_W-1:0] dbg_rd_val;

    // ------------------------------------------------------------
    // Debug acceptance. A debug write only goes in on a cycle with
    // no writeback, so at most one write commits per edge.
    // ------------------------------------------------------------
    always_comb begin
        dbg_idle_req = (state_q == DBG_IDLE) && dbg_req_i;
        dbg_rd_acc   = dbg_idle_req && !dbg_we_i;
        dbg_wr_acc   = dbg_idle_req && dbg_we_i && !reg_wen_i;
    end

    // ------------------------------------------------------------
    // Write selection: writeback wins, accepted debug write otherwise
    // ------------------------------------------------------------
    always_comb begin
        pipe_wr.en   = reg_wen_i;
        pipe_wr.addr = reg_waddr_i;
        pipe_wr.data = reg_wdata_i;

        dbg_wr.en    = dbg_wr_acc;
        dbg_wr.addr  = dbg_addr_i;
        dbg_wr.data  = dbg_wdata_i;

        wr = reg_wen_i ? pipe_wr : dbg_wr;
        wr_live = is_live_wr(wr);
    end

    // ------------------------------------------------------------
    // Next-state of the array; x0 is never written
    // ------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[wr.addr] = wr.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= ZERO_WORD;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------
    // Read port 1 with bypass from the committing write
    // ------------------------------------------------------------
    always_comb begin
        reg1_rdata_o = regs_q[reg1_raddr_i];
        if (reg1_raddr_i == ZERO_REG) begin
            reg1_rdata_o = ZERO_WORD;
        end else if (wr_live && (wr.addr == reg1_raddr_i)) begin
            reg1_rdata_o = wr.data;
        end
    end

    // ------------------------------------------------------------
    // Read port 2 with bypass from the committing write
    // ------------------------------------------------------------
    always_comb begin
        reg2_rdata_o = regs_q[reg2_raddr_i];
        if (reg2_raddr_i == ZERO_REG) begin
            reg2_rdata_o = ZERO_WORD;
        end else if (wr_live && (wr.addr == reg2_raddr_i)) begin
            reg2_rdata_o = wr.data;
        end
    end

    // ------------------------------------------------------------
    // Debug read value. Only a writeback can commit alongside an
    // accepted debug read, so only that path is bypassed here.
    // ------------------------------------------------------------
    always_comb begin
        dbg_rd_val = regs_q[dbg_addr_i];
        if (dbg_addr_i == ZERO_REG) begin
            dbg_rd_val = ZERO_WORD;
        end else if (is_live_wr(pipe_wr) && (reg_waddr_i == dbg_addr_i)) begin
            dbg_rd_val = reg_wdata_i;
        end
    end

    // ------------------------------------------------------------
    // Debug handshake FSM. The ack is asserted together with the
    // move into ACK so it is high for exactly that state. WAIT_LOW
    // blocks a still-held request from executing twice.
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DBG_IDLE;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= ZERO_WORD;
        end else begin
            unique case (state_q)
                DBG_IDLE: begin
                    dbg_ack_q <= 1'b0;
                    if (dbg_rd_acc) begin
                        dbg_rdata_q <= dbg_rd_val;
                        dbg_ack_q   <= 1'b1;
                        state_q     <= DBG_ACK;
                    end else if (dbg_wr_acc) begin
                        dbg_ack_q   <= 1'b1;
                        state_q     <= DBG_ACK;
                    end
                end
                DBG_ACK: begin
                    dbg_ack_q <= 1'b0;
                    state_q   <= DBG_WAIT_LOW;
                end
                DBG_WAIT_LOW: begin
                    dbg_ack_q <= 1'b0;
                    if (!dbg_req_i) begin
                        state_q <= DBG_IDLE;
                    end
                end
                default: begin
                    dbg_ack_q <= 1'b0;
                    state_q   <= DBG_IDLE;
                end
            endcase
        end
    end

    assign dbg_ack_o   = dbg_ack_q;
    assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for the register file: a reference model of the
// architectural state and debug handshake, plus directed scenarios.
module tb_regs;
    import regs_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [ADDR_W-1:0] reg1_raddr_i = '0;
    logic [ADDR_W-1:0] reg2_raddr_i = '0;
    logic [DATA_W-1:0] reg1_rdata_o;
    logic [DATA_W-1:0] reg2_rdata_o;
    logic              reg_wen_i = 1'b0;
    logic [ADDR_W-1:0] reg_waddr_i = '0;
    logic [DATA_W-1:0] reg_wdata_i = '0;
    logic              dbg_req_i = 1'b0;
    logic              dbg_we_i = 1'b0;
    logic [ADDR_W-1:0] dbg_addr_i = '0;
    logic [DATA_W-1:0] dbg_wdata_i = '0;
    logic              dbg_ack_o;
    logic [DATA_W-1:0] dbg_rdata_o;

    regs dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg1_raddr_i (reg1_raddr_i),
        .reg2_raddr_i (reg2_raddr_i),
        .reg1_rdata_o (reg1_rdata_o),
        .reg2_rdata_o (reg2_rdata_o),
        .reg_wen_i    (reg_wen_i),
        .reg_waddr_i  (reg_waddr_i),
        .reg_wdata_i  (reg_wdata_i),
        .dbg_req_i    (dbg_req_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_wdata_i  (dbg_wdata_i),
        .dbg_ack_o    (dbg_ack_o),
        .dbg_rdata_o  (dbg_rdata_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mem: architectural contents. m_ack: ack expected this cycle.
    // m_hold: an access was served and the request has not dropped.
    logic [31:0] mem [32];
    bit          m_ack;
    bit          m_hold;
    logic [31:0] m_rdata;
    bit          m_nack;
    bit          m_pwr;

    function automatic bit dbg_write_now();
        return !m_ack && !m_hold && dbg_req_i && dbg_we_i && !reg_wen_i;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (reg_wen_i && reg_waddr_i == a) return reg_wdata_i;
        if (!reg_wen_i && dbg_write_now() && dbg_addr_i == a)
            return dbg_wdata_i;
        return mem[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mem[i]) mem[i] = 32'h0;
            m_ack   = 0;
            m_hold  = 0;
            m_rdata = 32'h0;
        end else begin
            m_pwr  = reg_wen_i && reg_waddr_i != 0;
            m_nack = 0;
            if (!m_ack) begin
                if (m_hold) begin
                    if (!dbg_req_i) m_hold = 0;
                end else if (dbg_req_i) begin
                    if (!dbg_we_i) begin
                        if (dbg_addr_i == 0) m_rdata = 32'h0;
                        else if (m_pwr && reg_waddr_i == dbg_addr_i)
                            m_rdata = reg_wdata_i;
                        else m_rdata = mem[dbg_addr_i];
                        m_nack = 1;
                        m_hold = 1;
                    end else if (!reg_wen_i) begin
                        if (dbg_addr_i != 0) mem[dbg_addr_i] = dbg_wdata_i;
                        m_nack = 1;
                        m_hold = 1;
                    end
                end
            end
            if (m_pwr) mem[reg_waddr_i] = reg_wdata_i;
            m_ack = m_nack;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd1", reg1_rdata_o, exp_read(reg1_raddr_i));
            chk("rd2", reg2_rdata_o, exp_read(reg2_raddr_i));
            chk("ack", {31'h0, dbg_ack_o}, {31'h0, m_ack});
            chk("dbg_rdata", dbg_rdata_o, m_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [4:0]  wa_tab [6] = '{5'd1, 5'd2, 5'd31, 5'd10, 5'd2, 5'd0};
    logic [31:0] wd_tab [6] = '{32'h1, 32'h22222222, 32'hFFFFFFFF,
                                32'hA5A5A5A5, 32'h0BADF00D, 32'h77};
    int n_ack;

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'h0, dbg_ack_o}, 32'h0);
        chk("rst_rdata", dbg_rdata_o, 32'h0);
        rst_n = 1'b1;

        // 1: everything reads zero after reset
        for (int i = 0; i < 32; i++) begin
            step();
            reg1_raddr_i = 5'(i);
            reg2_raddr_i = 5'(31 - i);
            @(negedge clk);
            chk("init_rd1", reg1_rdata_o, 32'h0);
            chk("init_rd2", reg2_rdata_o, 32'h0);
        end

        // 2: bypass on write, persistence, x0 discard
        step();
        reg_wen_i = 1; reg_waddr_i = 5; reg_wdata_i = 32'hDEADBEEF;
        reg1_raddr_i = 5;
        @(negedge clk);
        chk("byp_x5", reg1_rdata_o, 32'hDEADBEEF);
        step();
        reg_wen_i = 0;
        @(negedge clk);
        chk("hold_x5", reg1_rdata_o, 32'hDEADBEEF);
        step();
        reg_wen_i = 1; reg_waddr_i = 0; reg_wdata_i = 32'h1234;
        reg1_raddr_i = 0; reg2_raddr_i = 0;
        @(negedge clk);
        chk("x0_byp", reg1_rdata_o, 32'h0);
        step();
        reg_wen_i = 0;
        @(negedge clk);
        chk("x0_after", reg2_rdata_o, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            reg_wen_i = 1; reg_waddr_i = wa_tab[i]; reg_wdata_i = wd_tab[i];
            reg1_raddr_i = wa_tab[i]; reg2_raddr_i = wa_tab[(i + 5) % 6];
        end
        step();
        reg_wen_i = 0;
        reg1_raddr_i = 2; reg2_raddr_i = 31;
        @(negedge clk);
        chk("tab_x2", reg1_rdata_o, 32'h0BADF00D);
        chk("tab_x31", reg2_rdata_o, 32'hFFFFFFFF);

        // 3: debug read, single ack while held, re-request
        step();
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 5;
        @(negedge clk);
        chk("rd_no_ack_yet", {31'h0, dbg_ack_o}, 32'h0);
        @(negedge clk);
        chk("rd_ack", {31'h0, dbg_ack_o}, 32'h1);
        chk("rd_data", dbg_rdata_o, 32'hDEADBEEF);
        repeat (4) begin
            @(negedge clk);
            chk("rd_no_reack", {31'h0, dbg_ack_o}, 32'h0);
        end
        step();
        dbg_req_i = 0;
        step();
        dbg_req_i = 1;
        @(negedge clk);
        chk("rereq_wait", {31'h0, dbg_ack_o}, 32'h0);
        @(negedge clk);
        chk("rereq_ack", {31'h0, dbg_ack_o}, 32'h1);
        chk("rereq_data", dbg_rdata_o, 32'hDEADBEEF);
        step();
        dbg_req_i = 0;
        repeat (2) step();

        // 4: debug write stalled behind writeback to the same register
        reg_wen_i = 1; reg_waddr_i = 7; reg_wdata_i = 32'hAA;
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 7; dbg_wdata_i = 32'h55;
        reg1_raddr_i = 7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_no_ack", {31'h0, dbg_ack_o}, 32'h0);
            chk("stall_rd_aa", reg1_rdata_o, 32'hAA);
            step();
        end
        reg_wen_i = 0;
        @(negedge clk);
        chk("dbgwr_byp", reg1_rdata_o, 32'h55);
        chk("dbgwr_no_ack", {31'h0, dbg_ack_o}, 32'h0);
        @(negedge clk);
        chk("dbgwr_ack", {31'h0, dbg_ack_o}, 32'h1);
        chk("dbgwr_x7", reg1_rdata_o, 32'h55);
        step();
        dbg_req_i = 0; dbg_we_i = 0;
        repeat (2) step();

        // 5: debug write bypassed to decode in the accepting cycle
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 3; dbg_wdata_i = 32'h11;
        reg2_raddr_i = 3; reg1_raddr_i = 5;
        @(negedge clk);
        chk("dbg_byp_x3", reg2_rdata_o, 32'h11);
        @(negedge clk);
        chk("x3_ack", {31'h0, dbg_ack_o}, 32'h1);

        // 6: reset in the ACK cycle, then one re-execution
        #1;
        rst_n = 0;
        #1;
        chk("rst_drop_ack", {31'h0, dbg_ack_o}, 32'h0);
        chk("rst_clr_x5", reg1_rdata_o, 32'h0);
        step();
        rst_n = 1;
        n_ack = 0;
        repeat (6) begin
            @(negedge clk);
            if (dbg_ack_o) n_ack++;
        end
        chk("rst_reack_cnt", 32'(n_ack), 32'h1);
        step();
        dbg_req_i = 0; dbg_we_i = 0;
        reg2_raddr_i = 3;
        @(negedge clk);
        chk("x3_rewritten", reg2_rdata_o, 32'h11);
        repeat (2) step();

        // 7: debug read bypasses a same-cycle writeback; read of x0
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 9;
        reg_wen_i = 1; reg_waddr_i = 9; reg_wdata_i = 32'hCAFE0009;
        step();
        reg_wen_i = 0;
        @(negedge clk);
        chk("dbgrd_byp_ack", {31'h0, dbg_ack_o}, 32'h1);
        chk("dbgrd_byp", dbg_rdata_o, 32'hCAFE0009);
        step();
        dbg_req_i = 0;
        repeat (2) step();
        dbg_req_i = 1; dbg_addr_i = 0;
        @(negedge clk);
        @(negedge clk);
        chk("dbgrd_x0", dbg_rdata_o, 32'h0);
        step();
        dbg_req_i = 0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
